// File: rtl/fifo_rd_streamer.sv
// Read-side streamer for fifo_controller: issues RAM reads and re-times the
// 1-cycle-latency read data into a valid/ready stream through a 2-entry skid buffer.
module fifo_rd_streamer #(
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_empty,
   output logic          o_rd,
   input  logic [DW-1:0] i_rdata,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data,
   output logic [1:0]    o_pending
);

   logic [1:0][DW-1:0] mem;
   logic               head, tail;
   logic [1:0]         occ, occ_next;
   logic               inflight;
   logic               push, pop;
   logic [2:0]         level;

   assign pop  = o_valid & i_ready;
   assign push = inflight;

   // Slots committed after this cycle; a read is only issued if its word has a guaranteed slot.
   assign level    = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
   assign o_rd     = ~i_rst & ~i_empty & (level < 3'd2);
   assign occ_next = occ + {1'b0, push} - {1'b0, pop};

   assign o_data    = mem[head];
   assign o_pending = occ + {1'b0, inflight};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mem      <= '0;
         head     <= 1'b0;
         tail     <= 1'b0;
         occ      <= 2'd0;
         inflight <= 1'b0;
         o_valid  <= 1'b0;
      end else begin
         inflight <= o_rd;
         if (push) begin
            mem[tail] <= i_rdata;
            tail      <= ~tail;
         end
         if (pop)
            head <= ~head;
         occ     <= occ_next;
         o_valid <= (occ_next != 2'd0);
      end
   end

   a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
      !(push && occ == 2'd2 && !pop));

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Randomized bench for fifo_rd_streamer: a RAM model feeds words, a scoreboard
// queue holds every word the streamer owes downstream, and a monitor checks it.
module tb_fifo_rd_streamer;

   localparam int DW = 8;

   logic          i_clk = 1'b0;
   logic          i_rst, i_empty, i_ready;
   logic          o_rd, o_valid;
   logic [DW-1:0] i_rdata, o_data;
   logic [1:0]    o_pending;

   fifo_rd_streamer #(.DW(DW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_empty(i_empty), .o_rd(o_rd),
      .i_rdata(i_rdata), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_pending(o_pending)
   );

   always #5 i_clk = ~i_clk;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] wcnt = 8'h10;
   logic          rd_seen = 1'b0;
   logic          bus_vld = 1'b0;
   logic          started = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock: drive inputs after the edge; the RAM answers last cycle's read.
   task automatic cyc(input logic rst, input logic emp, input logic rdy);
      @(posedge i_clk);
      #1;
      i_rst   = rst;
      i_empty = emp;
      i_ready = rdy;
      if (rd_seen) begin
         i_rdata = wcnt;
         bus_vld = 1'b1;
         if (!rst) exp_q.push_back(wcnt);
         wcnt = wcnt + 8'd1;
         if (wcnt == 8'hAA) wcnt = wcnt + 8'd1;
      end else begin
         i_rdata = 8'hAA;
         bus_vld = 1'b0;
      end
   endtask

   // Monitor: the queue holds buffered words plus the word on the bus this cycle.
   always @(negedge i_clk) begin
      if (started) begin
         int occ_m, pend_m;
         logic vld_m, pop_m, rd_m;
         occ_m  = exp_q.size() - ((bus_vld && !i_rst) ? 1 : 0);
         pend_m = occ_m + (bus_vld ? 1 : 0);
         vld_m  = (occ_m != 0);
         pop_m  = vld_m && i_ready;
         rd_m   = !i_rst && !i_empty && ((pend_m - (pop_m ? 1 : 0)) < 2);
         chk("valid", int'(o_valid), int'(vld_m));
         chk("pending", int'(o_pending), pend_m);
         chk("rd", int'(o_rd), int'(rd_m));
         if (vld_m && o_valid) chk("data", int'(o_data), int'(exp_q[0]));
         if (pop_m && exp_q.size() != 0) void'(exp_q.pop_front());
         if (i_rst) exp_q.delete();
         rd_seen = o_rd;
      end
   end

   initial begin
      i_rst = 1'b1; i_empty = 1'b1; i_ready = 1'b1; i_rdata = 8'hAA;
      cyc(1, 1, 1);
      started = 1'b1;
      cyc(1, 1, 1);
      chk("reset_data", int'(o_data), 0);
      chk("reset_pending", int'(o_pending), 0);
      // streaming at full rate
      for (int i = 0; i < 20; i++) cyc(0, 0, 1);
      // empty FIFO, nothing may be requested
      for (int i = 0; i < 10; i++) cyc(0, 1, 1);
      // backpressure then drain
      for (int i = 0; i < 6; i++) cyc(0, 0, 0);
      chk("bp_pending", int'(o_pending), 2);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1);
      // toggling empty with random ready
      for (int i = 0; i < 200; i++) cyc(0, i[0], 1'($urandom));
      // reset with a full buffer and with a read in flight
      for (int i = 0; i < 4; i++) cyc(0, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 1, 1);
      chk("rst_pending", int'(o_pending), 0);
      for (int i = 0; i < 2; i++) cyc(0, 0, 1);
      cyc(1, 0, 1);
      cyc(0, 1, 1);
      // single word
      for (int i = 0; i < 4; i++) cyc(0, 1, 1);
      cyc(0, 0, 1);
      for (int i = 0; i < 6; i++) cyc(0, 1, 1);
      // fully random including occasional reset
      for (int i = 0; i < 600; i++)
         cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0, 1'($urandom));
      for (int i = 0; i < 8; i++) cyc(0, 1, 1);
      chk("final_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
